regfile_wb_arbiter: RTL

Write-port controller for the 32x32 MIPS register file. It shares the file's single synchronous write port between two writeback requesters: A (ALU result path) and B (load/memory result path), using valid/ready handshakes and round-robin arbitration. After every reset it runs a clear sequence that writes zero into registers 1..31, so software never sees stale contents. It sits between the writeback stage and the register file's WriteData/WriteRegister/RegWrite inputs.

---
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: clears r1..r31 after reset,
// then round-robin arbitrates the single write port between the ALU (A) and load (B) writebacks.
module regfile_wb_arbiter (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ValidA,
   input  logic [4:0]  AddrA,
   input  logic [31:0] DataA,
   output logic        ReadyA,
   input  logic        ValidB,
   input  logic [4:0]  AddrB,
   input  logic [31:0] DataB,
   output logic        ReadyB,
   output logic        RegWrite,
   output logic [4:0]  WriteRegister,
   output logic [31:0] WriteData,
   output logic        Busy
);

   localparam logic S_CLEAR = 1'b0;
   localparam logic S_RUN   = 1'b1;

   localparam logic PTR_A = 1'b0;
   localparam logic PTR_B = 1'b1;

   localparam logic [4:0] LAST_REG = 5'd31;

   logic       state;
   logic       ptr;
   logic [4:0] clr_cnt;

   logic       grant_a;
   logic       grant_b;
   logic [4:0] win_addr;
   logic [31:0] win_data;

   // Grant depends only on the valids, the state and the pointer, never on Addr/Data.
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      win_addr = AddrA;
      win_data = DataA;
      if (state == S_RUN) begin
         if (ValidA && ValidB) begin
            grant_a = (ptr == PTR_A);
            grant_b = (ptr == PTR_B);
         end else begin
            grant_a = ValidA;
            grant_b = ValidB;
         end
      end
      if (grant_b) begin
         win_addr = AddrB;
         win_data = DataB;
      end
   end

   assign ReadyA = grant_a;
   assign ReadyB = grant_b;

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= S_CLEAR;
         ptr           <= PTR_A;
         clr_cnt       <= 5'd1;
         RegWrite      <= 1'b0;
         WriteRegister <= 5'd0;
         WriteData     <= 32'd0;
         Busy          <= 1'b1;
      end else begin
         case (state)
            S_CLEAR: begin
               RegWrite      <= 1'b1;
               WriteRegister <= clr_cnt;
               WriteData     <= 32'd0;
               if (clr_cnt == LAST_REG) begin
                  state <= S_RUN;
                  Busy  <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 5'd1;
               end
            end
            default: begin
               if (grant_a || grant_b) begin
                  // r0 is hardwired zero: the handshake completes but the write is dropped.
                  RegWrite      <= (win_addr != 5'd0);
                  WriteRegister <= win_addr;
                  WriteData     <= win_data;
                  ptr           <= grant_a ? PTR_B : PTR_A;
               end else begin
                  RegWrite <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
